// File: rtl/shifter_pkg.sv
// Shared encodings for the pipelined barrel shifter: operation codes,
// direction constants and the shift-amount width helper.
package shifter_pkg;

  localparam logic [1:0] SH_LOGIC = 2'b00;
  localparam logic [1:0] SH_ROT   = 2'b01;
  localparam logic [1:0] SH_ARITH = 2'b10;

  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;

  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel stage: optionally shifts/rotates by 2^K and
// replaces the running carry with the last bit that left the word.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       op,
  input  logic             c_in,
  output logic [WIDTH-1:0] q,
  output logic             c_out
);

  localparam int S = 1 << K;

  logic [S-1:0] fill_r;
  logic [S-1:0] fill_l;

  // Op 11 falls through to the zero fill, i.e. behaves as logical.
  always_comb begin
    fill_r = '0;
    fill_l = '0;
    if (op == SH_ROT) begin
      fill_r = d[S-1:0];
      fill_l = d[WIDTH-1:WIDTH-S];
    end else if (op == SH_ARITH) begin
      fill_r = {S{d[WIDTH-1]}};
    end
  end

  always_comb begin
    q     = d;
    c_out = c_in;
    if (en) begin
      if (dir == DIR_RIGHT) begin
        q     = {fill_r, d[WIDTH-1:S]};
        c_out = d[S-1];
      end else begin
        q     = {d[WIDTH-S-1:0], fill_l};
        c_out = d[WIDTH-S];
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, with a
// valid/ready stream on both sides; a stall freezes the whole pipeline.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int SHW   = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_c,
  output logic             out_z
);

  logic [WIDTH-1:0] data_reg  [SHW];
  logic [SHW-1:0]   amt_reg   [SHW];
  logic [1:0]       op_reg    [SHW];
  logic             dir_reg   [SHW];
  logic             c_reg     [SHW];
  logic             valid_reg [SHW];
  logic             adv;

  assign out_valid = valid_reg[SHW-1];
  assign out_data  = data_reg[SHW-1];
  assign out_c     = c_reg[SHW-1];
  // Gated by valid so the flag reads 0 after reset even though data is zero.
  assign out_z     = out_valid && (out_data == '0);
  assign in_ready  = (!out_valid || out_ready) && !flush;
  assign adv       = in_ready;

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
      logic [WIDTH-1:0] d_src;
      logic [WIDTH-1:0] d_next;
      logic [SHW-1:0]   amt_src;
      logic [1:0]       op_src;
      logic             dir_src;
      logic             c_src;
      logic             c_next;
      logic             v_src;

      if (gi == 0) begin : g_head
        assign d_src   = in_data;
        assign amt_src = in_amt;
        assign op_src  = in_op;
        assign dir_src = in_dir;
        assign c_src   = 1'b0;
        assign v_src   = in_valid;
      end else begin : g_body
        assign d_src   = data_reg[gi-1];
        assign amt_src = amt_reg[gi-1];
        assign op_src  = op_reg[gi-1];
        assign dir_src = dir_reg[gi-1];
        assign c_src   = c_reg[gi-1];
        assign v_src   = valid_reg[gi-1];
      end

      shift_stage #(
        .WIDTH (WIDTH),
        .K     (gi)
      ) u_stage (
        .d     (d_src),
        .en    (amt_src[gi]),
        .dir   (dir_src),
        .op    (op_src),
        .c_in  (c_src),
        .q     (d_next),
        .c_out (c_next)
      );

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
          amt_reg[gi]   <= '0;
          op_reg[gi]    <= SH_LOGIC;
          dir_reg[gi]   <= DIR_LEFT;
          c_reg[gi]     <= 1'b0;
        end else if (flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (adv) begin
          // Bubbles move with the data; empty slots are never collapsed.
          valid_reg[gi] <= v_src;
          data_reg[gi]  <= d_next;
          amt_reg[gi]   <= amt_src;
          op_reg[gi]    <= op_src;
          dir_reg[gi]   <= dir_src;
          c_reg[gi]     <= c_next;
        end
      end
    end
  endgenerate

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the team's 8-bit combinational barrel shifter. Shifts or rotates a WIDTH-bit word left or right by 0..WIDTH-1 positions in logical, rotate or arithmetic mode, and produces carry and zero flags. One register stage per shift-amount bit, with a valid/ready stream handshake on both sides. Sits between the ALU operand mux and the result writeback path, where a single-cycle shifter no longer meets timing at wider datapaths.

Parameters:
WIDTH, 8, data width; must be a power of two and >= 2.
SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
in_valid  in  1  input word present.
in_ready  out  1  block accepts input this cycle.
in_data  in  WIDTH  operand.
in_amt  in  SHW  shift amount.
in_dir  in  1  1 = right, 0 = left.
in_op  in  2  00 logical, 01 rotate, 10 arithmetic, 11 treated as logical.
flush  in  1  synchronous pipeline clear.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts result.
out_data  out  WIDTH  result.
out_c  out  1  carry: last bit shifted or rotated out.
out_z  out  1  1 when out_data == 0.

Behaviour:
- Reset: when rst_n = 0 at a clk edge, all stage valids clear. After that edge: out_valid = 0, out_data = 0, out_c = 0, out_z = 0. Reset mid-operation drops every in-flight item; none is emitted.
- Pipeline: SHW stages. Stage k applies a shift of 2^k when amt bit k is set, otherwise passes data through. Each stage registers data, the remaining amt bits, dir, op, running carry and valid.
- Latency: a word accepted at edge N appears on out_* after edge N+SHW, with no stalls.
- Handshake: in_ready = !out_valid || out_ready. It is also forced to 0 while flush = 1.
  - Transfer in: in_valid && in_ready.
  - Transfer out: out_valid && out_ready.
  - When in_ready = 0, every stage holds, so out_* stay stable while out_valid && !out_ready.
  - Bubbles propagate and are not collapsed.
- Flush: clears all stage valids at the edge and accepts no input that cycle. Result as for reset, except data registers need not be zeroed; out_valid = 0 next cycle.
- Amount 0: out_data = in_data, out_c = 0, for every op and dir.
- Right, amount a > 0:
  - Logical fills with 0.
  - Rotate: bits leaving bit 0 enter bit WIDTH-1.
  - Arithmetic fills with in_data[WIDTH-1].
  - out_c = in_data[a-1] in all three modes.
- Left, amount a > 0:
  - Logical and arithmetic are identical; both fill with 0.
  - Rotate: bits leaving bit WIDTH-1 enter bit 0.
  - out_c = in_data[WIDTH-a].
- Carry tracking: a stage with its amt bit set overwrites the running carry with the last bit it shifts out. A stage with its amt bit clear keeps the running carry.
- out_z is computed from the final-stage data. It is valid whenever out_valid is valid.
- Simultaneous in and out transfer at full occupancy: legal, the pipeline advances one slot, and throughput is 1 word/cycle.

Decomposition:
- Package shifter_pkg holds:
  - op encodings SH_LOGIC = 2'b00, SH_ROT = 2'b01, SH_ARITH = 2'b10;
  - direction constants DIR_RIGHT = 1'b1, DIR_LEFT = 1'b0;
  - a function returning SHW from WIDTH.
- Sub-module shift_stage, parametrised by WIDTH and stage index K:
  - combinational 2^K shift/rotate with fill selection and carry-out select;
  - instantiated SHW times in a generate loop.
- Top level owns the stage registers, valid chain, stall and flush.

Test Plan:
(WIDTH = 8, data = 8'b1010_1111 unless stated.)
1. Right logical amt 1 -> 8'b0101_0111, c = 1; amt 2 -> 8'b0010_1011, c = 1; amt 0 -> 8'b1010_1111, c = 0, z = 0. Each result appears exactly 3 cycles after acceptance.
2. Right rotate amt 2 -> 8'b1110_1011, c = 1. Right arithmetic amt 3 -> 8'b1111_0101, c = 1. Op 11 amt 3 -> 8'b0001_0101 (logical).
3. Left logical amt 1 -> 8'b0101_1110, c = 1. Left rotate amt 2 -> 8'b1011_1110, c = 0. Left arithmetic amt 2 -> 8'b1011_1100, c = 0.
4. Zero flag: data 8'b0000_0001, right logical amt 1 -> out 8'h00, c = 1, z = 1.
5. Back-to-back stream of 6 words with out_ready = 0 for cycles 4-7:
   - in_ready = 0 while stalled with out_valid = 1;
   - out_* hold constant;
   - all 6 results emerge in order, none lost or duplicated.
6. Two words in flight:
   - rst_n = 0 for one edge -> out_valid = 0, out_data = 0, out_c = 0, out_z = 0, and neither word appears afterwards;
   - repeat the same setup with flush instead of reset -> same out_valid behaviour, and in_ready = 0 during the flush cycle.
